// File: rtl/multich_mic_dma.sv
// Multichannel microphone capture DMA: planar sample layout over an Avalon-MM master.
// Optional circular capture is enabled by defining MIC_DMA_CIRCULAR_EN.
module multich_mic_dma #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  output logic [31:0]              AM_ADDR,
  output logic                     AM_WRITE,
  output logic [31:0]              AM_WRITEDATA,
  output logic [3:0]               AM_BYTEENABLE,
  input  logic                     AM_WAITREQUEST,
  input  logic [NUM_CH*DATA_W-1:0] mic_data,
  input  logic                     mic_valid,
  input  logic                     start,
  input  logic [31:0]              start_address,
  input  logic [31:0]              number_samples,
  output logic                     FINISHED,
  output logic                     BUSY,
  output logic                     overrun
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    WRITE,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] len_q, len_d;
  logic [31:0] n_q, n_d;
  logic [31:0] addr_q, addr_d;
  logic [CW-1:0] c_q, c_d;
  logic [NUM_CH*DATA_W-1:0] frame_q, frame_d;
  logic ovr_q, ovr_d;
  logic stop_q, stop_d;
  logic pulse_q, pulse_d;
  logic [31:0] n_inc;
  logic [DATA_W-1:0] sample;

  // State register and datapath flops, synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      c_q     <= '0;
      frame_q <= '0;
      ovr_q   <= 1'b0;
      stop_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      c_q     <= c_d;
      frame_q <= frame_d;
      ovr_q   <= ovr_d;
      stop_q  <= stop_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state: frame capture, per-channel write walk, completion
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    n_d     = n_q;
    addr_d  = addr_q;
    c_d     = c_q;
    frame_d = frame_q;
    ovr_d   = ovr_q;
    stop_d  = stop_q;
    pulse_d = 1'b0;
    n_inc   = n_q + 32'd1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d = start_address;
          len_d  = number_samples;
          n_d    = '0;
          c_d    = '0;
          stop_d = 1'b0;
          if (number_samples == 32'd0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_FRAME;
            ovr_d   = 1'b0;
          end
        end
      end
      WAIT_FRAME: begin
        if (!start) begin
          state_d = DONE;
        end else if (mic_valid) begin
          frame_d = mic_data;
          c_d     = '0;
          addr_d  = base_q + {n_q[29:0], 2'b00};
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (mic_valid) ovr_d = 1'b1;
        if (!start) stop_d = 1'b1;
        if (!AM_WAITREQUEST) begin
          if (c_q != LAST_CH) begin
            c_d    = c_q + CW'(1);
            addr_d = addr_q + {len_q[29:0], 2'b00};
          end else begin
            c_d     = '0;
            n_d     = n_inc;
            state_d = WAIT_FRAME;
            if (n_inc == len_q) begin
`ifdef MIC_DMA_CIRCULAR_EN
              n_d     = '0;
              pulse_d = 1'b1;
`else
              state_d = DONE;
`endif
            end
            if (stop_q || !start) state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; write data is the current channel, zero-extended
  always_comb begin
    sample       = frame_q[c_q*DATA_W +: DATA_W];
    AM_WRITEDATA = '0;
    if (state_q == WRITE) AM_WRITEDATA[DATA_W-1:0] = sample;
    AM_WRITE      = (state_q == WRITE);
    AM_ADDR       = addr_q;
    AM_BYTEENABLE = 4'hF;
    BUSY          = (state_q == WAIT_FRAME) || (state_q == WRITE);
    FINISHED      = (state_q == DONE) || pulse_q;
    overrun       = ovr_q;
  end

endmodule

// File: tb/tb_multich_mic_dma.sv
// Directed bench for multich_mic_dma with a queue-based memory-write model.
// Circular-mode scenario is compiled only when MIC_DMA_CIRCULAR_EN is defined.
module tb_multich_mic_dma;

  localparam int NCH = 4;
  localparam int DW  = 32;

  logic CLK = 1'b0;
  logic RESET;
  logic [31:0] AM_ADDR;
  logic AM_WRITE;
  logic [31:0] AM_WRITEDATA;
  logic [3:0] AM_BYTEENABLE;
  logic AM_WAITREQUEST;
  logic [NCH*DW-1:0] mic_data;
  logic mic_valid;
  logic start;
  logic [31:0] start_address;
  logic [31:0] number_samples;
  logic FINISHED;
  logic BUSY;
  logic overrun;

  always #5 CLK = ~CLK;

  multich_mic_dma #(.NUM_CH(NCH), .DATA_W(DW)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .AM_ADDR(AM_ADDR),
    .AM_WRITE(AM_WRITE),
    .AM_WRITEDATA(AM_WRITEDATA),
    .AM_BYTEENABLE(AM_BYTEENABLE),
    .AM_WAITREQUEST(AM_WAITREQUEST),
    .mic_data(mic_data),
    .mic_valid(mic_valid),
    .start(start),
    .start_address(start_address),
    .number_samples(number_samples),
    .FINISHED(FINISHED),
    .BUSY(BUSY),
    .overrun(overrun)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int vectors = 0;
  int miscompares = 0;
  wr_t exp_q[$];
  logic [31:0] wlog[$];
  logic [31:0] dlog[$];
  logic [31:0] m_base, m_len, m_n;
  int pulses = 0;
  logic hold_v = 1'b0;
  logic [31:0] hold_a, hold_d;
  logic [31:0] exp033 [8] = '{32'h1000, 32'h1008, 32'h1010, 32'h1018,
                              32'h1004, 32'h100C, 32'h1014, 32'h101C};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fdata(input int f, input int c);
    return 32'hC0DE0000 + 32'(f * 16 + c);
  endfunction

  task automatic model_start(input logic [31:0] b, input logic [31:0] len);
    m_base = b;
    m_len  = len;
    m_n    = 0;
  endtask

  // Planar layout: channel c, sample n lands at base + 4*(c*N + n)
  task automatic model_frame(input int f);
    for (int c = 0; c < NCH; c++)
      exp_q.push_back('{m_base + (32'(c) * m_len + m_n) * 32'd4, fdata(f, c)});
    m_n = m_n + 1;
    if (m_n == m_len) m_n = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int f, input bit accepted);
    for (int c = 0; c < NCH; c++) mic_data[c*DW +: DW] = fdata(f, c);
    mic_valid = 1'b1;
    if (accepted) model_frame(f);
    tick();
    mic_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      tick();
      if (exp_q.size() == 0 && AM_WRITE !== 1'b1) break;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Compare accepted writes against the model; check hold during stalls
  always @(negedge CLK) begin
    if (AM_WRITE === 1'b1) begin
      if (hold_v) begin
        check("hold_addr", AM_ADDR, hold_a);
        check("hold_data", AM_WRITEDATA, hold_d);
      end
      if (AM_WAITREQUEST) begin
        hold_v = 1'b1;
        hold_a = AM_ADDR;
        hold_d = AM_WRITEDATA;
      end else begin
        hold_v = 1'b0;
        wlog.push_back(AM_ADDR);
        dlog.push_back(AM_WRITEDATA);
        if (exp_q.size() == 0) begin
          check("unexpected_write", AM_ADDR, 32'hFFFF_FFFF);
        end else begin
          check("wr_addr", AM_ADDR, exp_q[0].addr);
          check("wr_data", AM_WRITEDATA, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
    end else begin
      hold_v = 1'b0;
    end
    if (FINISHED === 1'b1 && BUSY === 1'b1) pulses++;
  end

  initial begin
    RESET = 1'b1;
    start = 1'b0;
    mic_valid = 1'b0;
    mic_data = '0;
    AM_WAITREQUEST = 1'b0;
    start_address = '0;
    number_samples = '0;
    tick();
    tick();
    check("rst_write", AM_WRITE, 0);
    check("rst_addr", AM_ADDR, 0);
    check("rst_data", AM_WRITEDATA, 0);
    check("rst_fin", FINISHED, 0);
    check("rst_busy", BUSY, 0);
    check("rst_ovr", overrun, 0);
    check("byteen", AM_BYTEENABLE, 4'hF);
    RESET = 1'b0;
    tick();

    // Two frames, N=2, planar addresses; input changes after latch ignored
    start_address = 32'h1000;
    number_samples = 2;
    model_start(32'h1000, 2);
    wlog.delete();
    dlog.delete();
    start = 1'b1;
    tick();
    check("busy_wait", BUSY, 1);
    send(0, 1);
    check("lat_write", AM_WRITE, 1);
    check("lat_addr", AM_ADDR, 32'h1000);
    start_address = 32'hDEAD0000;
    number_samples = 7;
    repeat (4) tick();
    check("frame_end_write", AM_WRITE, 0);
    check("frame_end_cnt", wlog.size(), 4);
    repeat (5) tick();
    send(1, 1);
    drain();
    for (int i = 0; i < 8; i++) check("addr033", wlog[i], exp033[i]);
`ifndef MIC_DMA_CIRCULAR_EN
    check("done_fin", FINISHED, 1);
    check("done_busy", BUSY, 0);
`endif
    start = 1'b0;
    tick();
    tick();
    check("idle_fin", FINISHED, 0);
    check("idle_busy", BUSY, 0);

    // Waitstates on the channel-1 write
    start_address = 32'h2000;
    number_samples = 1;
    model_start(32'h2000, 1);
    wlog.delete();
    dlog.delete();
    start = 1'b1;
    tick();
    send(2, 1);
    tick();
    AM_WAITREQUEST = 1'b1;
    check("ws_addr0", AM_ADDR, 32'h2004);
    check("ws_data0", AM_WRITEDATA, fdata(2, 1));
    tick();
    check("ws_addr1", AM_ADDR, 32'h2004);
    tick();
    check("ws_addr2", AM_ADDR, 32'h2004);
    tick();
    AM_WAITREQUEST = 1'b0;
    check("ws_addr3", AM_ADDR, 32'h2004);
    check("ws_data3", AM_WRITEDATA, fdata(2, 1));
    drain();
    check("ws_count", wlog.size(), 4);
    start = 1'b0;
    tick();
    tick();

    // Overrun: second strobe while writing is dropped
    start_address = 32'h3000;
    number_samples = 2;
    model_start(32'h3000, 2);
    wlog.delete();
    dlog.delete();
    start = 1'b1;
    tick();
    send(3, 1);
    tick();
    send(4, 0);
    check("ovr_set", overrun, 1);
    drain();
    check("ovr_count", wlog.size(), 4);
    check("ovr_busy", BUSY, 1);
    send(5, 1);
    drain();
    check("ovr_count2", wlog.size(), 8);
    check("ovr_addr4", wlog[4], 32'h3004);
    start = 1'b0;
    tick();
    tick();
    check("ovr_sticky", overrun, 1);

    // N=0: straight to DONE, no writes, overrun untouched
    start_address = 32'h7000;
    number_samples = 0;
    start = 1'b1;
    tick();
    check("n0_fin", FINISHED, 1);
    check("n0_busy", BUSY, 0);
    check("n0_write", AM_WRITE, 0);
    check("n0_ovr", overrun, 1);
    repeat (3) tick();
    check("n0_fin_hold", FINISHED, 1);
    start = 1'b0;
    tick();
    check("n0_idle_fin", FINISHED, 0);

    // start falls mid-frame: frame completes then DONE
    start_address = 32'h8000;
    number_samples = 4;
    model_start(32'h8000, 4);
    wlog.delete();
    dlog.delete();
    start = 1'b1;
    tick();
    check("ovr_clear", overrun, 0);
    send(6, 1);
    tick();
    start = 1'b0;
    drain();
    check("stop_count", wlog.size(), 4);
    check("stop_fin", FINISHED, 1);
    check("stop_busy", BUSY, 0);
    send(7, 0);
    repeat (3) tick();
    check("stop_nomore", wlog.size(), 4);

    // Reset while a write is stalled, then a fresh capture
    start_address = 32'h4000;
    number_samples = 2;
    model_start(32'h4000, 2);
    start = 1'b1;
    tick();
    send(8, 1);
    AM_WAITREQUEST = 1'b1;
    tick();
    RESET = 1'b1;
    tick();
    check("rstw_write", AM_WRITE, 0);
    check("rstw_busy", BUSY, 0);
    exp_q.delete();
    RESET = 1'b0;
    AM_WAITREQUEST = 1'b0;
    start_address = 32'h5000;
    number_samples = 1;
    model_start(32'h5000, 1);
    wlog.delete();
    dlog.delete();
    tick();
    check("rstw_restart", BUSY, 1);
    send(9, 1);
    drain();
    check("rstw_count", wlog.size(), 4);
    check("rstw_addr0", wlog[0], 32'h5000);
    check("rstw_addr3", wlog[3], 32'h500C);
    start = 1'b0;
    tick();
    tick();

`ifdef MIC_DMA_CIRCULAR_EN
    // Circular: 5 frames, N=2, wrap pulses after frames 2 and 4
    start_address = 32'h6000;
    number_samples = 2;
    model_start(32'h6000, 2);
    wlog.delete();
    dlog.delete();
    start = 1'b1;
    tick();
    pulses = 0;
    for (int f = 0; f < 5; f++) begin
      send(10 + f, 1);
      repeat (7) tick();
    end
    drain();
    check("circ_pulses", pulses, 2);
    check("circ_f3_addr", wlog[8], 32'h6000);
    check("circ_f3_data", dlog[8], fdata(12, 0));
    check("circ_busy", BUSY, 1);
    start = 1'b0;
    tick();
    tick();
    check("circ_idle", BUSY, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
